// File: rtl/pipe_fifo_pkg.sv
// Shared helpers for the width-converting pipe FIFO.
// Holds the lane-order enum and the width/ratio derivation functions.
`default_nettype none

package pipe_fifo_pkg;

  typedef enum logic {
    LANE_MSB_FIRST = 1'b0,
    LANE_LSB_FIRST = 1'b1
  } lane_order_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int lane_width(input int wr_w, input int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int lanes_per_word(input int word_w, input int wr_w, input int rd_w);
    return word_w / lane_width(wr_w, rd_w);
  endfunction

  function automatic int count_width(input int words);
    return clog2(words) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_fifo_ram.sv
// Simple dual-port lane RAM: multi-lane write port, registered multi-lane read port.
// Lane k of each port word maps to address + k; callers keep addresses step-aligned.
`default_nettype none

module pipe_fifo_ram #(
  parameter int N     = 32,
  parameter int LANES = 1024,
  parameter int WL    = 1,
  parameter int RL    = 8,
  parameter int AW    = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [WL*N-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [RL*N-1:0] rdata_o
);

  logic [N-1:0]    mem_q [LANES];
  logic [RL*N-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < WL; k++) begin
        mem_q[waddr_i + AW'(k)] <= wdata_i[k*N +: N];
      end
    end
  end

  // Read register is cleared with the FIFO so a stale word never reappears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int k = 0; k < RL; k++) begin
        rdata_q[k*N +: N] <= mem_q[raddr_i + AW'(k)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pipe_width_fifo.sv
// Single-clock width-converting FIFO with sticky error flags, flush and
// registered block-granular throttle flags for both sides.
`default_nettype none

module pipe_width_fifo
  import pipe_fifo_pkg::*;
#(
  parameter int WR_W      = 32,
  parameter int RD_W      = 256,
  parameter int DEPTH     = 1024,
  parameter int WR_BLOCK  = 128,
  parameter int RD_BLOCK  = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         flush,
  input  logic [WR_W-1:0]                              din,
  input  logic                                         wr_en,
  input  logic                                         rd_en,
  output logic [RD_W-1:0]                              dout,
  output logic                                         valid,
  output logic                                         full,
  output logic                                         empty,
  output logic [count_width(DEPTH)-1:0]                wr_count,
  output logic [count_width(DEPTH*WR_W/RD_W)-1:0]      rd_count,
  output logic                                         wr_block_ready,
  output logic                                         rd_block_ready,
  output logic                                         overflow,
  output logic                                         underflow
);

  localparam int N     = lane_width(WR_W, RD_W);
  localparam int WL    = lanes_per_word(WR_W, WR_W, RD_W);
  localparam int RL    = lanes_per_word(RD_W, WR_W, RD_W);
  localparam int LANES = DEPTH * WL;
  localparam int PW    = clog2(LANES);
  localparam int OW    = PW + 1;
  localparam int WSH   = clog2(WL);
  localparam int RSH   = clog2(RL);
  localparam int RCW   = count_width(DEPTH*WR_W/RD_W);
  localparam lane_order_e ORDER = (MSB_FIRST != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          valid_q;
  logic          overflow_q, underflow_q;
  logic          wr_block_ready_q, rd_block_ready_q;
  logic          wr_block_ready_d, rd_block_ready_d;

  logic [OW-1:0]   free_lanes;
  logic            wr_accept, rd_accept;
  logic [WL*N-1:0] ram_wdata;
  logic [RL*N-1:0] ram_rdata;

  assign free_lanes = OW'(LANES) - occ_q;
  assign full       = free_lanes < OW'(WL);
  assign empty      = occ_q < OW'(RL);
  assign wr_count   = occ_q[OW-1:WSH];
  assign rd_count   = occ_q[OW-1:RSH];
  assign wr_accept  = wr_en & ~full;
  assign rd_accept  = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(WL);
      occ_d    = occ_d + OW'(WL);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(RL);
      occ_d    = occ_d - OW'(RL);
    end
    // Comparing lanes against WR_BLOCK*WL equals comparing floor(free words).
    wr_block_ready_d = free_lanes >= OW'(WR_BLOCK * WL);
    rd_block_ready_d = rd_count >= RCW'(RD_BLOCK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      valid_q          <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      wr_block_ready_q <= 1'b0;
      rd_block_ready_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      valid_q          <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      wr_block_ready_q <= 1'b0;
      rd_block_ready_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      valid_q          <= rd_accept;
      overflow_q       <= overflow_q | (wr_en & full);
      underflow_q      <= underflow_q | (rd_en & empty);
      wr_block_ready_q <= wr_block_ready_d;
      rd_block_ready_q <= rd_block_ready_d;
    end
  end

  // Lane 0 of each RAM port word is always the earliest lane in stream order.
  for (genvar k = 0; k < WL; k++) begin : g_wr_lane
    if (ORDER == LANE_MSB_FIRST) begin : g_msb
      assign ram_wdata[k*N +: N] = din[WR_W-1-k*N -: N];
    end else begin : g_lsb
      assign ram_wdata[k*N +: N] = din[k*N +: N];
    end
  end

  for (genvar k = 0; k < RL; k++) begin : g_rd_lane
    if (ORDER == LANE_MSB_FIRST) begin : g_msb
      assign dout[RD_W-1-k*N -: N] = ram_rdata[k*N +: N];
    end else begin : g_lsb
      assign dout[k*N +: N] = ram_rdata[k*N +: N];
    end
  end

  pipe_fifo_ram #(
    .N     (N),
    .LANES (LANES),
    .WL    (WL),
    .RL    (RL),
    .AW    (PW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (flush),
    .we_i    (wr_accept & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (rd_accept & ~flush),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign valid          = valid_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign wr_block_ready = wr_block_ready_q;
  assign rd_block_ready = rd_block_ready_q;

endmodule

`default_nettype wire
